// File: rtl/demux2_pkg.sv
// ---------------------------------------------------------------------------
// demux2_pkg
// Shared constants and types for the two-way buffered demultiplexer.
//   W_DEFAULT : default data width of the datapath
//   DEPTH     : entries held by each per-channel output buffer
//   occ_e     : occupancy level of a two-entry buffer, encoded as its count
//   cnt_t     : width of the per-channel delivery counters
// ---------------------------------------------------------------------------
package demux2_pkg;

  localparam int W_DEFAULT = 8;
  localparam int DEPTH     = 2;

  // The encoding is the word count, so the value can be compared with DEPTH
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef logic [7:0] cnt_t;

endpackage

// File: rtl/demux2_buf_fifo2.sv
// ---------------------------------------------------------------------------
// fifo2
// Two-entry synchronous FIFO used as the output buffer of one channel.
// The head word is always visible on data_o; it reads zero after reset.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset, empties the FIFO
//   push_i  : write data_i this cycle (ignored while full)
//   data_i  : word to write
//   pop_i   : drop the head word this cycle (ignored while empty)
//   data_o  : head word
//   full_o  : FIFO holds DEPTH words
//   empty_o : FIFO holds no words
// ---------------------------------------------------------------------------
module fifo2
  import demux2_pkg::*;
#(
  parameter int W     = demux2_pkg::W_DEFAULT,
  parameter int DEPTH = demux2_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  occ_e         occ_q, occ_d;
  logic         rdPtr_q, rdPtr_d;
  logic         wrPtr_q, wrPtr_d;
  logic [W-1:0] mem_q [2];
  logic         doPush;
  logic         doPop;

  assign full_o  = (int'(occ_q) >= DEPTH);
  assign empty_o = (occ_q == OCC_EMPTY);
  assign data_o  = mem_q[rdPtr_q];

  // Guard the requests locally so an illegal push or pop never moves state
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Occupancy and pointer next-state; a push together with a pop only
  // moves the pointers, so the count is unchanged and order is preserved
  always_comb begin
    occ_d   = occ_q;
    rdPtr_d = rdPtr_q ^ doPop;
    wrPtr_d = wrPtr_q ^ doPush;
    case ({doPush, doPop})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // State register; storage is cleared too so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      rdPtr_q  <= 1'b0;
      wrPtr_q  <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q   <= occ_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/demux2_buf.sv
// ---------------------------------------------------------------------------
// demux2_buf
// Routes each accepted input word to one of two independently buffered
// output channels and counts the words delivered on each channel.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   a, s, in_valid     : input word, destination select (0 -> y0, 1 -> y1)
//                        and its valid flag
//   in_ready           : the buffer chosen by s has room this cycle
//   y0/y1              : head word of channel 0 / 1
//   y0_valid/y1_valid  : channel buffer is non-empty
//   y0_ready/y1_ready  : consumer takes the head word this cycle
//   cnt0/cnt1          : wrapping count of words delivered on channel 0 / 1
// ---------------------------------------------------------------------------
module demux2_buf
  import demux2_pkg::*;
#(
  parameter int W     = demux2_pkg::W_DEFAULT,
  parameter int DEPTH = demux2_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic         s,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic         y0_valid,
  output logic         y1_valid,
  input  logic         y0_ready,
  input  logic         y1_ready,
  output cnt_t         cnt0,
  output cnt_t         cnt1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  cnt_t cnt0_q, cnt0_d;
  cnt_t cnt1_q, cnt1_d;

  // Ready depends only on the selected buffer's current fill, never on a
  // same-cycle pop, so a full channel stays closed for one more cycle
  assign in_ready = s ? !full1 : !full0;

  assign push0 = in_valid && in_ready && !s;
  assign push1 = in_valid && in_ready && s;

  assign y0_valid = !empty0;
  assign y1_valid = !empty1;
  assign pop0     = y0_valid && y0_ready;
  assign pop1     = y1_valid && y1_ready;

  fifo2 #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push0),
    .data_i  (a),
    .pop_i   (pop0),
    .data_o  (y0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  fifo2 #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push1),
    .data_i  (a),
    .pop_i   (pop1),
    .data_o  (y1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  // Delivery counters advance on every pop and wrap naturally at 8 bits
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) begin
      cnt0_d = cnt0_q + 8'd1;
    end
    if (pop1) begin
      cnt1_d = cnt1_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule
